sram_dp_arbiter: RTL and testbench
==================================

# sram_dp_arbiter

Shares one 1024x32 dual-port SRAM macro (HL28HKHDDP1024x32BIM4W1P0MSA10) among NUM_REQ octree requesters. Each cycle it grants up to two requests, one per macro port, in round-robin order and drives the macro port pins. It returns read data one cycle after grant. It sits between the octree engines and the macro instance; the wrapper ties the macro test pins (TEST1x, RMEx, RMx, LS).

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..8.
- ADDR_W, default 10: address width.
- DATA_W, default 32: data and mask width.
- clk_i, in, 1: single clock; it also drives the macro CLKA and CLKB.
- rst_ni, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, NUM_REQ: request valid, one bit per requester.
- req_ready_o, out, NUM_REQ: grant. A request is accepted when valid and ready are both high.
- req_we_i, in, NUM_REQ: 1 = write, 0 = read.
- req_addr_i, in, NUM_REQ x ADDR_W: word address.
- req_wdata_i, in, NUM_REQ x DATA_W: write data.
- req_wmask_i, in, NUM_REQ x DATA_W: bit write mask; 1 = write that bit.
- rsp_valid_o, out, NUM_REQ: read-data-valid pulse.
- rsp_rdata_o, out, NUM_REQ x DATA_W: read data; meaningful only while rsp_valid_o is high.
- init_done_o, out, 1: the array is usable.
- sram_mea_o / sram_meb_o, out, 1: port chip enables.
- sram_wea_o / sram_web_o, out, 1: port write enables.
- sram_adra_o / sram_adrb_o, out, ADDR_W: port addresses.
- sram_da_o / sram_db_o, out, DATA_W: port write data.
- sram_wema_o / sram_wemb_o, out, DATA_W: port write masks.
- sram_qa_i / sram_qb_i, in, DATA_W: port read data. Data is valid in the cycle after ME was sampled high.

## Operation
- States: INIT and RUN. INIT exists only with the Configuration macro defined; otherwise the block resets into RUN.
- Arbitration in RUN, combinational from req_valid_i and the rr pointer ptr:
  - Port A goes to the first valid requester at or after ptr, in cyclic order.
  - Port B goes to the next valid requester after the port A winner.
- Conflict rule: if the A and B winners have the same address and either one writes, B is not granted in that cycle.
- ptr update: ptr becomes (last granted index + 1) mod NUM_REQ. It holds when there is no grant.
- A granted port drives ME=1, WE=req_we_i, and the winner's addr, data and mask. An ungranted port drives ME=0, WE=0, and zeros on all buses.
- Per port, one pipeline register holds the owner index and a read flag.
  - In the cycle after a read grant, rsp_valid_o[owner]=1 and rsp_rdata_o[owner] = that port's Q.
  - Writes produce no response.
- With one grant per port per cycle, a requester receives at most one response per cycle.
- Requesters with no grant see ready=0 and must hold their request stable; valid must not drop before ready.

## Timing
- Grant and macro drive happen in the same cycle as valid (ready depends on valid).
- Read latency: grant at cycle t gives rsp_valid_o at t+1. Peak throughput is 2 accesses per cycle.
- Reset values: ptr=0, pipeline flags 0, all sram_* outputs 0, req_ready_o=0 and rsp_valid_o=0 during reset.
- init_done_o at reset: 0 with the macro defined, 1 without it.
- Reset asserted mid-operation drops pending responses. INIT restarts when rst_ni deasserts.
- Single-requester starvation bound: at most NUM_REQ-1 cycles of waiting.

## Configuration
- SRAM_DP_ARBITER_INIT_EN defined:
  - After reset, INIT zero-fills the array. Counter k runs 0..511: port A writes address 2k and port B writes 2k+1, with data 0 and mask all ones.
  - req_ready_o stays 0 throughout INIT.
  - After the k=511 cycle the block enters RUN and init_done_o rises in the next cycle, 512 cycles after reset release.
- SRAM_DP_ARBITER_INIT_EN undefined: no INIT state, no counter, init_done_o is constant 1, and array contents are undefined after power-up.

## Structure
- Package sram_dp_arbiter_pkg holds:
  - SRAM_DEPTH=1024, SRAM_ADDR_W=10, SRAM_DATA_W=32.
  - The state_e enum {INIT, RUN}.
  - The port_pipe_t struct {valid, owner, is_rd}.
- One sub-module, rr_pick2: given the valid vector and ptr, it outputs the A and B grant one-hots and the last-granted index. It is purely combinational.

## Test plan
- Init (macro defined): release reset, then 512 cycles of paired zero writes on both ports; init_done_o=1 at cycle 512; any read returns 0x00000000.
- Single read: r0 writes 0xDEADBEEF to address 5 with full mask; r1 reads address 5 later; rsp_valid_o[1] pulses one cycle after grant with 0xDEADBEEF.
- Masked write: write 0xFFFFFFFF with mask 0x0000FFFF onto a zeroed word, then read; result is 0x0000FFFF.
- Contention: all four requesters hold valid with ptr=0; grants are {0,1}, then {2,3}, then {0,1}; each sees a response one cycle after its grant.
- Conflict: r0 writes address 7 and r1 reads address 7 in the same cycle; only r0 is granted, and r1 is granted next cycle and reads the new data.
- Reset mid-read: assert rst_ni low while a read grant is in flight; no rsp_valid_o fires and all sram_* outputs are 0 immediately.

Source files
------------

// File: rtl/sram_dp_arbiter_pkg.sv
// Shared constants and types for the dual-port SRAM arbiter.
package sram_dp_arbiter_pkg;

  localparam int unsigned SRAM_DEPTH  = 1024;
  localparam int unsigned SRAM_ADDR_W = 10;
  localparam int unsigned SRAM_DATA_W = 32;

  // Zero-fill covers two words per cycle, one per port.
  localparam int unsigned INIT_CNT_W = 9;
  localparam int unsigned INIT_LAST  = SRAM_DEPTH / 2 - 1;

  // Wide enough for the largest legal requester count (8).
  localparam int unsigned OWNER_W = 3;

  typedef enum logic [0:0] {INIT, RUN} state_e;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
    logic               is_rd;
  } port_pipe_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_dp_arbiter_rr_pick2.sv
// Combinational round-robin picker: first two valid requesters at or after ptr.
module sram_dp_arbiter_rr_pick2 #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_a_o,
  output logic [NUM_REQ-1:0] gnt_b_o,
  output logic               a_found_o,
  output logic               b_found_o,
  output logic [IdxW-1:0]    a_idx_o,
  output logic [IdxW-1:0]    b_idx_o,
  output logic [IdxW-1:0]    last_idx_o
);

  int unsigned     j;
  logic [IdxW-1:0] jj;
  logic            a_hit, b_hit;

  always_comb begin
    gnt_a_o = '0;
    gnt_b_o = '0;
    a_hit   = 1'b0;
    b_hit   = 1'b0;
    a_idx_o = '0;
    b_idx_o = '0;
    j       = 0;
    jj      = '0;
    // Scanning from ptr, the second hit is the next valid requester after A.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = i + 32'(ptr_i);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IdxW'(j);
      if (valid_i[jj]) begin
        if (!a_hit) begin
          a_hit       = 1'b1;
          a_idx_o     = jj;
          gnt_a_o[jj] = 1'b1;
        end else if (!b_hit) begin
          b_hit       = 1'b1;
          b_idx_o     = jj;
          gnt_b_o[jj] = 1'b1;
        end
      end
    end
    a_found_o  = a_hit;
    b_found_o  = b_hit;
    last_idx_o = b_hit ? b_idx_o : a_idx_o;
  end

endmodule

// File: rtl/sram_dp_arbiter.sv
// Two-grant round-robin arbiter in front of a 1024x32 dual-port SRAM macro.
// Define SRAM_DP_ARBITER_INIT_EN to zero-fill the array after every reset.
module sram_dp_arbiter
  import sram_dp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0]             req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wmask_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [NUM_REQ-1:0][DATA_W-1:0] rsp_rdata_o,
  output logic                           init_done_o,
  output logic                           sram_mea_o,
  output logic                           sram_meb_o,
  output logic                           sram_wea_o,
  output logic                           sram_web_o,
  output logic [ADDR_W-1:0]              sram_adra_o,
  output logic [ADDR_W-1:0]              sram_adrb_o,
  output logic [DATA_W-1:0]              sram_da_o,
  output logic [DATA_W-1:0]              sram_db_o,
  output logic [DATA_W-1:0]              sram_wema_o,
  output logic [DATA_W-1:0]              sram_wemb_o,
  input  logic [DATA_W-1:0]              sram_qa_i,
  input  logic [DATA_W-1:0]              sram_qb_i
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic                  active, in_init;
  logic [INIT_CNT_W-1:0] init_cnt;

`ifdef SRAM_DP_ARBITER_INIT_EN
  state_e                state_q;
  logic [INIT_CNT_W-1:0] init_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_CNT_W'(INIT_LAST)) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign active      = (state_q == RUN);
  assign in_init     = (state_q == INIT);
  assign init_cnt    = init_cnt_q;
  assign init_done_o = (state_q == RUN);
`else
  assign active      = 1'b1;
  assign in_init     = 1'b0;
  assign init_cnt    = '0;
  assign init_done_o = 1'b1;
`endif

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_a, gnt_b;
  logic               a_found, b_found;
  logic [IdxW-1:0]    a_idx, b_idx, last_idx, last_gnt;

  sram_dp_arbiter_rr_pick2 #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick2 (
    .valid_i    (req_valid_i),
    .ptr_i      (ptr_q),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b),
    .a_found_o  (a_found),
    .b_found_o  (b_found),
    .a_idx_o    (a_idx),
    .b_idx_o    (b_idx),
    .last_idx_o (last_idx)
  );

  logic conflict, grant_a, grant_b;

  // Same word with a write on either side would make the B access order-dependent.
  assign conflict = a_found && b_found && (req_addr_i[a_idx] == req_addr_i[b_idx]) &&
                    (req_we_i[a_idx] || req_we_i[b_idx]);
  assign grant_a  = active && a_found;
  assign grant_b  = active && b_found && !conflict;
  assign last_gnt = conflict ? a_idx : last_idx;
  assign ptr_d    = grant_a ? IdxW'(wrap_inc(32'(last_gnt), NUM_REQ)) : ptr_q;

  logic              mea, meb, wea, web;
  logic [ADDR_W-1:0] adra, adrb;
  logic [DATA_W-1:0] da, db, wema, wemb;

  always_comb begin
    mea  = 1'b0;
    meb  = 1'b0;
    wea  = 1'b0;
    web  = 1'b0;
    adra = '0;
    adrb = '0;
    da   = '0;
    db   = '0;
    wema = '0;
    wemb = '0;
    if (in_init) begin
      mea  = 1'b1;
      meb  = 1'b1;
      wea  = 1'b1;
      web  = 1'b1;
      adra = ADDR_W'({init_cnt, 1'b0});
      adrb = ADDR_W'({init_cnt, 1'b1});
      wema = '1;
      wemb = '1;
    end else begin
      if (grant_a) begin
        mea  = 1'b1;
        wea  = req_we_i[a_idx];
        adra = req_addr_i[a_idx];
        da   = req_wdata_i[a_idx];
        wema = req_wmask_i[a_idx];
      end
      if (grant_b) begin
        meb  = 1'b1;
        web  = req_we_i[b_idx];
        adrb = req_addr_i[b_idx];
        db   = req_wdata_i[b_idx];
        wemb = req_wmask_i[b_idx];
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the request inputs.
  assign sram_mea_o  = rst_ni & mea;
  assign sram_meb_o  = rst_ni & meb;
  assign sram_wea_o  = rst_ni & wea;
  assign sram_web_o  = rst_ni & web;
  assign sram_adra_o = rst_ni ? adra : '0;
  assign sram_adrb_o = rst_ni ? adrb : '0;
  assign sram_da_o   = rst_ni ? da   : '0;
  assign sram_db_o   = rst_ni ? db   : '0;
  assign sram_wema_o = rst_ni ? wema : '0;
  assign sram_wemb_o = rst_ni ? wemb : '0;

  assign req_ready_o = rst_ni ? ((grant_a ? gnt_a : '0) | (grant_b ? gnt_b : '0)) : '0;

  port_pipe_t pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;

  always_comb begin
    pipe_a_d       = '0;
    pipe_b_d       = '0;
    pipe_a_d.valid = grant_a;
    pipe_a_d.owner = OWNER_W'(a_idx);
    pipe_a_d.is_rd = grant_a & ~req_we_i[a_idx];
    pipe_b_d.valid = grant_b;
    pipe_b_d.owner = OWNER_W'(b_idx);
    pipe_b_d.is_rd = grant_b & ~req_we_i[b_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      pipe_a_q <= '0;
      pipe_b_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      pipe_a_q <= pipe_a_d;
      pipe_b_q <= pipe_b_d;
    end
  end

  // A and B owners always differ, so the two ports never collide on a requester.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pipe_a_q.valid && pipe_a_q.is_rd && pipe_a_q.owner == OWNER_W'(i)) begin
        rsp_valid_o[i] = 1'b1;
        rsp_rdata_o[i] = sram_qa_i;
      end
      if (pipe_b_q.valid && pipe_b_q.is_rd && pipe_b_q.owner == OWNER_W'(i)) begin
        rsp_valid_o[i] = 1'b1;
        rsp_rdata_o[i] = sram_qb_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Bench for sram_dp_arbiter: macro model, reference model compared every cycle,
// and directed scenarios with literal expectations.
module tb_sram_dp_arbiter;

  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MAXW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid, req_ready, req_we, rsp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata, req_wmask, rsp_rdata;
  logic                 init_done, mea, meb, wea, web;
  logic [AW-1:0]        adra, adrb;
  logic [DW-1:0]        da, db, wema, wemb, qa, qb;

  sram_dp_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wmask_i (req_wmask),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .init_done_o (init_done),
    .sram_mea_o  (mea),
    .sram_meb_o  (meb),
    .sram_wea_o  (wea),
    .sram_web_o  (web),
    .sram_adra_o (adra),
    .sram_adrb_o (adrb),
    .sram_da_o   (da),
    .sram_db_o   (db),
    .sram_wema_o (wema),
    .sram_wemb_o (wemb),
    .sram_qa_i   (qa),
    .sram_qb_i   (qb)
  );

  // Dual-port macro: Q valid the cycle after ME sampled high.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mea) begin
      if (wea) mem[adra] <= (mem[adra] & ~wema) | (da & wema);
      qa <= mem[adra];
    end
    if (meb) begin
      if (web) mem[adrb] <= (mem[adrb] & ~wemb) | (db & wemb);
      qb <= mem[adrb];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] exp_mem [1024];
  bit            known [1024];
  int            mptr;
  int            init_k;
  logic [N-1:0]  pend_v, pend_k;
  logic [DW-1:0] pend_d [N];
  logic [DW-1:0] last_rsp [N];
  int            rsp_cnt [N] = '{0, 0, 0, 0};

  function automatic logic [75:0] port_exp(input int p);
    if (p < 0) return '0;
    return {1'b1, req_we[p], req_addr[p], req_wdata[p], req_wmask[p]};
  endfunction

  task automatic model_access(input int p, input bit do_write);
    logic [AW-1:0] ad;
    if (p < 0) return;
    ad = req_addr[p];
    if (!do_write && !req_we[p]) begin
      pend_v[p] = 1'b1;
      pend_k[p] = known[ad];
      pend_d[p] = exp_mem[ad];
    end
    if (do_write && req_we[p]) begin
      exp_mem[ad] = (exp_mem[ad] & ~req_wmask[p]) | (req_wdata[p] & req_wmask[p]);
      if (req_wmask[p] == 32'hFFFF_FFFF) known[ad] = 1'b1;
    end
  endtask

  task automatic model_run();
    int a, b, last;
    logic [N-1:0] er;
    a = -1;
    b = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (mptr + i) % N;
      if (req_valid[j]) begin
        if (a < 0) a = j;
        else if (b < 0) b = j;
      end
    end
    if (b >= 0 && req_addr[a] == req_addr[b] && (req_we[a] || req_we[b])) b = -1;
    er = '0;
    if (a >= 0) er[a] = 1'b1;
    if (b >= 0) er[b] = 1'b1;
    chk("ready", req_ready, er);
    chk("port_a", {mea, wea, adra, da, wema}, port_exp(a));
    chk("port_b", {meb, web, adrb, db, wemb}, port_exp(b));
    model_access(a, 1'b0);
    model_access(b, 1'b0);
    model_access(a, 1'b1);
    model_access(b, 1'b1);
    if (a >= 0) begin
      last = (b >= 0) ? b : a;
      mptr = (last + 1) % N;
    end
  endtask

  always @(negedge clk) begin : model
    if (!rst_n) begin
      chk("rst_ready", req_ready, '0);
      chk("rst_sram", {mea, meb, wea, web, adra, adrb, da, db}, '0);
      chk("rst_wem", {wema, wemb}, '0);
      chk("rst_rsp", rsp_valid, '0);
      mptr   = 0;
      init_k = 0;
      pend_v = '0;
      pend_k = '0;
    end else begin
      chk("rsp_valid", rsp_valid, pend_v);
      for (int i = 0; i < N; i++) begin
        if (pend_v[i] && pend_k[i]) chk("rsp_rdata", rsp_rdata[i], pend_d[i]);
        if (rsp_valid[i]) begin
          last_rsp[i] = rsp_rdata[i];
          rsp_cnt[i]++;
        end
      end
      pend_v = '0;
      pend_k = '0;
`ifdef SRAM_DP_ARBITER_INIT_EN
      chk("init_done", init_done, init_k >= 512);
      if (init_k < 512) begin
        chk("init_ready", req_ready, '0);
        chk("init_a", {mea, wea, adra, da, wema},
            {1'b1, 1'b1, AW'(2 * init_k), 32'h0, 32'hFFFF_FFFF});
        chk("init_b", {meb, web, adrb, db, wemb},
            {1'b1, 1'b1, AW'(2 * init_k + 1), 32'h0, 32'hFFFF_FFFF});
        exp_mem[2 * init_k]     = '0;
        exp_mem[2 * init_k + 1] = '0;
        known[2 * init_k]       = 1'b1;
        known[2 * init_k + 1]   = 1'b1;
        init_k++;
      end else begin
        model_run();
      end
`else
      chk("init_done", init_done, 1'b1);
      model_run();
`endif
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = ad;
    req_wdata[i] = wd;
    req_wmask[i] = wm;
  endtask

  task automatic wait_grants();
    logic [N-1:0] g;
    int n = 0;
    while (req_valid != '0 && n < MAXW) begin
      @(negedge clk);
      g = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~g;
      n++;
    end
    chk("grant_timeout", req_valid, '0);
    req_valid = '0;
  endtask

  task automatic wait_init();
`ifdef SRAM_DP_ARBITER_INIT_EN
    int n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (init_done) break;
      n++;
    end
    chk("init_cycles", n, 512);
    tick();
`else
    tick();
`endif
  endtask

  initial begin
    logic [N-1:0] hist [3];
    int c0 [N];
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;

    // Requests present during reset must not be granted.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0, '0);
    repeat (3) tick();
    chk("reset_ready_lit", req_ready, 4'b0000);
    chk("reset_me_lit", {mea, meb}, 2'b00);
`ifdef SRAM_DP_ARBITER_INIT_EN
    chk("reset_init_done_lit", init_done, 1'b0);
`else
    chk("reset_init_done_lit", init_done, 1'b1);
`endif
    req_valid = '0;
    rst_n = 1'b1;
    wait_init();

    // Single write then read.
    set_req(0, 1'b1, 10'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    wait_grants();
    set_req(1, 1'b0, 10'd5, '0, '0);
    wait_grants();
    tick();
    chk("single_read_lit", last_rsp[1], 32'hDEAD_BEEF);

    // Masked write onto a zeroed word.
    set_req(2, 1'b1, 10'd9, 32'h0, 32'hFFFF_FFFF);
    wait_grants();
    set_req(2, 1'b1, 10'd9, 32'hFFFF_FFFF, 32'h0000_FFFF);
    wait_grants();
    set_req(3, 1'b0, 10'd9, '0, '0);
    wait_grants();
    tick();
    chk("masked_write_lit", last_rsp[3], 32'h0000_FFFF);

    // Contention: pointer is back at 0 here; all four hold valid for three cycles.
    for (int i = 0; i < N; i++) c0[i] = rsp_cnt[i];
    set_req(0, 1'b0, 10'd5, '0, '0);
    set_req(1, 1'b0, 10'd9, '0, '0);
    set_req(2, 1'b0, 10'd5, '0, '0);
    set_req(3, 1'b0, 10'd9, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      hist[c] = req_ready;
      tick();
    end
    req_valid = '0;
    tick();
    chk("contention_c0", hist[0], 4'b0011);
    chk("contention_c1", hist[1], 4'b1100);
    chk("contention_c2", hist[2], 4'b0011);
    for (int i = 0; i < N; i++) chk("contention_rsp_cnt", rsp_cnt[i] - c0[i], (i < 2) ? 2 : 1);
    chk("contention_data2", last_rsp[2], 32'hDEAD_BEEF);
    chk("contention_data3", last_rsp[3], 32'h0000_FFFF);

    // Conflict: write and read of address 7 in the same cycle.
    set_req(0, 1'b1, 10'd7, 32'h1234_5678, 32'hFFFF_FFFF);
    set_req(1, 1'b0, 10'd7, '0, '0);
    @(negedge clk);
    hist[0] = req_ready;
    tick();
    req_valid = req_valid & ~hist[0];
    @(negedge clk);
    hist[1] = req_ready;
    tick();
    req_valid = req_valid & ~hist[1];
    wait_grants();
    tick();
    chk("conflict_c0", hist[0], 4'b0001);
    chk("conflict_c1", hist[1], 4'b0010);
    chk("conflict_data", last_rsp[1], 32'h1234_5678);

    // Reset while a read grant is in flight.
    set_req(2, 1'b0, 10'd7, '0, '0);
    @(negedge clk);
    chk("rstmid_grant_lit", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_sram_lit", {mea, meb, wea, web, adra, adrb}, '0);
    chk("rstmid_ready_lit", req_ready, 4'b0000);
    chk("rstmid_rsp_lit", rsp_valid, 4'b0000);
    @(negedge clk);
    chk("rstmid_norsp_lit", rsp_valid, 4'b0000);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_init();

`ifdef SRAM_DP_ARBITER_INIT_EN
    set_req(0, 1'b0, 10'd5, '0, '0);
    wait_grants();
    tick();
    chk("post_init_zero_lit", last_rsp[0], 32'h0);
`else
    set_req(0, 1'b0, 10'd7, '0, '0);
    wait_grants();
    tick();
    chk("post_reset_read_lit", last_rsp[0], 32'h1234_5678);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
